// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//
// Purpose:
//   Control sequencer for a multi-cycle MIPS-subset datapath. The datapath has
//   one shared memory, one ALU and the IR/PC/A/B/ALUOut registers. Each
//   instruction walks through FETCH, DECODE, an execute state and a
//   writeback state. Every datapath select and write enable, plus the ALU
//   operation code, is decoded from the current state. Memory accesses stall
//   on the mem_ready handshake.
//
//   A watchdog counts consecutive not-ready cycles in a memory wait state. If
//   the count reaches WAIT_MAX, the sequencer parks in HALT with a sticky
//   timeout flag. Only rst leaves HALT.
//
// Configuration macro:
//   MC_CTRL_JUMP_EN - when defined, opcode 02 (j) is executed through the
//                     JUMP state. When undefined, that state is not built
//                     and opcode 02 is reported as illegal.
//
// Parameters:
//   FUNC_ADD  ALU code used for address, PC+4 and addi adds
//   FUNC_SUB  ALU code used for the beq compare
//   WAIT_MAX  max consecutive mem_ready=0 cycles in one wait state (0 = off)
//
// Ports:
//   clk        in   1  clock, rising edge
//   rst        in   1  synchronous active-high reset
//   opcode     in   6  IR[31:26], stable from DECODE to end of instruction
//   funct      in   6  IR[5:0]
//   zero       in   1  ALU zero flag
//   mem_ready  in   1  memory access completes this cycle
//   func_in    out  6  ALU operation code
//   RegDst     out  1  1 = rd, 0 = rt
//   ALUSrcA    out  1  0 = PC, 1 = A
//   ALUSrcB    out  2  00 = B, 01 = 4, 10 = sext imm, 11 = sext imm << 2
//   RegWrite   out  1  register file write enable
//   MemRead    out  1  memory read request
//   MemWrite   out  1  memory write request
//   MemToReg   out  1  1 = MDR, 0 = ALUOut to register file
//   IorD       out  1  0 = PC, 1 = ALUOut as memory address
//   IRWrite    out  1  IR load enable
//   PCWrite    out  1  unconditional PC load
//   Branch     out  1  conditional PC load qualifier
//   PCSrc      out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
//   PCEn       out  1  PCWrite | (Branch & zero)
//   state      out  4  current state (debug)
//   instr_done out  1  pulse in the last cycle of each retired instruction
//   illegal    out  1  pulse when an unsupported opcode is decoded
//   timeout    out  1  sticky memory-wait timeout flag
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter logic [5:0]  FUNC_ADD = 6'b100000,
    parameter logic [5:0]  FUNC_SUB = 6'b100010,
    parameter int unsigned WAIT_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [5:0] func_in,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemToReg,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal,
    output logic       timeout
);

    // ------------------------------------------------------------------
    // State encoding (fixed values, visible on the debug port)
    // ------------------------------------------------------------------
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
`ifdef MC_CTRL_JUMP_EN
    localparam logic [3:0] S_JUMP   = 4'd11;
`endif
    localparam logic [3:0] S_HALT   = 4'd12;

    // Supported opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
`ifdef MC_CTRL_JUMP_EN
    localparam logic [5:0] OP_J     = 6'h02;
`endif
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // The wait counter only needs to hold values up to WAIT_MAX.
    localparam int             CNT_W    = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);
    localparam logic           WAIT_EN  = (WAIT_MAX != 0) ? 1'b1 : 1'b0;

    // ------------------------------------------------------------------
    // Opcode decode helper: returns {illegal, next_state} for DECODE.
    // ------------------------------------------------------------------
    function automatic logic [4:0] f_decode(input logic [5:0] op);
        logic [4:0] res;
        case (op)
            OP_LW:    res = {1'b0, S_MEMADR};
            OP_SW:    res = {1'b0, S_MEMADR};
            OP_RTYPE: res = {1'b0, S_EXEC};
            OP_BEQ:   res = {1'b0, S_BRANCH};
            OP_ADDI:  res = {1'b0, S_ADDIEX};
`ifdef MC_CTRL_JUMP_EN
            OP_J:     res = {1'b0, S_JUMP};
`endif
            default:  res = {1'b1, S_FETCH};
        endcase
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Registers and internal wires
    // ------------------------------------------------------------------
    logic [3:0]       r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_timeout;

    logic [4:0]       w_dec;
    logic [3:0]       w_seq_next;
    logic [3:0]       w_next_state;
    logic             w_wait_state;
    logic             w_wait_stall;
    logic             w_wait_expire;

    logic [5:0]       w_func;
    logic             w_reg_dst;
    logic             w_alu_src_a;
    logic [1:0]       w_alu_src_b;
    logic             w_reg_write;
    logic             w_mem_read;
    logic             w_mem_write;
    logic             w_mem_to_reg;
    logic             w_iord;
    logic             w_ir_write;
    logic             w_pc_write;
    logic             w_branch;
    logic [1:0]       w_pc_src;
    logic             w_instr_done;
    logic             w_illegal;

    assign w_dec = f_decode(opcode);

    // Wait-state detection and watchdog expiry; a ready cycle always wins.
    always_comb begin
        w_wait_state  = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
        w_wait_stall  = w_wait_state && !mem_ready;
        w_wait_expire = WAIT_EN && w_wait_stall && (r_wait_cnt == WAIT_LIM);
    end

    // Sequencing: next state ignoring the watchdog.
    always_comb begin
        w_seq_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (mem_ready) begin
                    w_seq_next = S_DECODE;
                end else begin
                    w_seq_next = S_FETCH;
                end
            end
            S_DECODE: w_seq_next = w_dec[3:0];
            S_MEMADR: begin
                if (opcode == OP_LW) begin
                    w_seq_next = S_MEMRD;
                end else begin
                    w_seq_next = S_MEMWR;
                end
            end
            S_MEMRD: begin
                if (mem_ready) begin
                    w_seq_next = S_MEMWB;
                end else begin
                    w_seq_next = S_MEMRD;
                end
            end
            S_MEMWB:  w_seq_next = S_FETCH;
            S_MEMWR: begin
                if (mem_ready) begin
                    w_seq_next = S_FETCH;
                end else begin
                    w_seq_next = S_MEMWR;
                end
            end
            S_EXEC:   w_seq_next = S_ALUWB;
            S_ALUWB:  w_seq_next = S_FETCH;
            S_BRANCH: w_seq_next = S_FETCH;
            S_ADDIEX: w_seq_next = S_ADDIWB;
            S_ADDIWB: w_seq_next = S_FETCH;
`ifdef MC_CTRL_JUMP_EN
            S_JUMP:   w_seq_next = S_FETCH;
`endif
            S_HALT:   w_seq_next = S_HALT;
            // Unreachable encodings recover to a clean fetch.
            default:  w_seq_next = S_FETCH;
        endcase
    end

    assign w_next_state = w_wait_expire ? S_HALT : w_seq_next;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Consecutive not-ready counter; cleared by a ready cycle or any state
    // change, saturating so it cannot wrap when the watchdog is disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= {CNT_W{1'b0}};
        end else if (w_wait_stall && (w_next_state == r_state)) begin
            if (&r_wait_cnt) begin
                r_wait_cnt <= r_wait_cnt;
            end else begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
        end else begin
            r_wait_cnt <= {CNT_W{1'b0}};
        end
    end

    // Sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout <= 1'b0;
        end else if (w_wait_expire) begin
            r_timeout <= 1'b1;
        end else begin
            r_timeout <= r_timeout;
        end
    end

    // Per-state control decode; anything not set in a state stays 0.
    always_comb begin
        w_func       = FUNC_ADD;
        w_reg_dst    = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = 2'b00;
        w_reg_write  = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_iord       = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_pc_src     = 2'b00;
        w_instr_done = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                // IR load and PC+4 commit only when the read completes.
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                w_ir_write  = mem_ready;
                w_pc_write  = mem_ready;
            end
            S_DECODE: begin
                // ALU precomputes the branch target into ALUOut.
                w_alu_src_b = 2'b11;
                w_illegal   = w_dec[4];
            end
            S_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                w_iord     = 1'b1;
                w_mem_read = 1'b1;
            end
            S_MEMWB: begin
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            S_MEMWR: begin
                w_iord       = 1'b1;
                w_mem_write  = 1'b1;
                w_instr_done = mem_ready;
            end
            S_EXEC: begin
                w_alu_src_a = 1'b1;
                w_func      = funct;
            end
            S_ALUWB: begin
                w_reg_dst    = 1'b1;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            S_ADDIEX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            S_BRANCH: begin
                // Compare A-B; PC loads the DECODE-time target from ALUOut.
                w_alu_src_a  = 1'b1;
                w_func       = FUNC_SUB;
                w_branch     = 1'b1;
                w_pc_src     = 2'b01;
                w_instr_done = 1'b1;
            end
`ifdef MC_CTRL_JUMP_EN
            S_JUMP: begin
                w_pc_src     = 2'b10;
                w_pc_write   = 1'b1;
                w_instr_done = 1'b1;
            end
`endif
            S_HALT: begin
                w_func = 6'b000000;
            end
            default: begin
                w_func = 6'b000000;
            end
        endcase
    end

    // Output stage: everything is forced low while rst is asserted.
    always_comb begin
        if (rst) begin
            func_in    = 6'b000000;
            RegDst     = 1'b0;
            ALUSrcA    = 1'b0;
            ALUSrcB    = 2'b00;
            RegWrite   = 1'b0;
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            MemToReg   = 1'b0;
            IorD       = 1'b0;
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            Branch     = 1'b0;
            PCSrc      = 2'b00;
            PCEn       = 1'b0;
            state      = 4'd0;
            instr_done = 1'b0;
            illegal    = 1'b0;
            timeout    = 1'b0;
        end else begin
            func_in    = w_func;
            RegDst     = w_reg_dst;
            ALUSrcA    = w_alu_src_a;
            ALUSrcB    = w_alu_src_b;
            RegWrite   = w_reg_write;
            MemRead    = w_mem_read;
            MemWrite   = w_mem_write;
            MemToReg   = w_mem_to_reg;
            IorD       = w_iord;
            IRWrite    = w_ir_write;
            PCWrite    = w_pc_write;
            Branch     = w_branch;
            PCSrc      = w_pc_src;
            PCEn       = w_pc_write | (w_branch & zero);
            state      = r_state;
            instr_done = w_instr_done;
            illegal    = w_illegal;
            timeout    = r_timeout;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Directed bench for multicycle_ctrl (WAIT_MAX = 4). Inputs change 1 ns after
// the rising edge. The full output vector is compared against a hand-built
// expectation at each falling edge.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

    typedef struct packed {
        logic [5:0] func_in;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic [1:0] pc_src;
        logic       pc_en;
        logic [3:0] st;
        logic       instr_done;
        logic       illegal;
        logic       timeout;
    } outs_t;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic [5:0] func_in;
    logic       RegDst;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       MemToReg;
    logic       IorD;
    logic       IRWrite;
    logic       PCWrite;
    logic       Branch;
    logic [1:0] PCSrc;
    logic       PCEn;
    logic [3:0] state;
    logic       instr_done;
    logic       illegal;
    logic       timeout;

    outs_t act;
    int    total = 0;
    int    bad   = 0;

    multicycle_ctrl #(.WAIT_MAX(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .func_in(func_in), .RegDst(RegDst),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
        .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch),
        .PCSrc(PCSrc), .PCEn(PCEn), .state(state), .instr_done(instr_done),
        .illegal(illegal), .timeout(timeout)
    );

    assign act = {func_in, RegDst, ALUSrcA, ALUSrcB, RegWrite, MemRead, MemWrite,
                  MemToReg, IorD, IRWrite, PCWrite, Branch, PCSrc, PCEn, state,
                  instr_done, illegal, timeout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output vectors, written per state from the control table.
    function automatic outs_t e_zero();
        outs_t e;
        e = '0;
        return e;
    endfunction

    function automatic outs_t e_base(input logic [3:0] st);
        outs_t e;
        e = '0;
        e.func_in = 6'b100000;
        e.st = st;
        return e;
    endfunction

    function automatic outs_t e_fetch(input logic mr);
        outs_t e;
        e = e_base(4'd0);
        e.mem_read = 1'b1; e.alu_src_b = 2'b01;
        e.ir_write = mr; e.pc_write = mr; e.pc_en = mr;
        return e;
    endfunction

    function automatic outs_t e_decode(input logic ill);
        outs_t e;
        e = e_base(4'd1);
        e.alu_src_b = 2'b11; e.illegal = ill;
        return e;
    endfunction

    function automatic outs_t e_memadr();
        outs_t e;
        e = e_base(4'd2);
        e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        return e;
    endfunction

    function automatic outs_t e_memrd();
        outs_t e;
        e = e_base(4'd3);
        e.iord = 1'b1; e.mem_read = 1'b1;
        return e;
    endfunction

    function automatic outs_t e_memwb();
        outs_t e;
        e = e_base(4'd4);
        e.mem_to_reg = 1'b1; e.reg_write = 1'b1; e.instr_done = 1'b1;
        return e;
    endfunction

    function automatic outs_t e_memwr(input logic mr);
        outs_t e;
        e = e_base(4'd5);
        e.iord = 1'b1; e.mem_write = 1'b1; e.instr_done = mr;
        return e;
    endfunction

    function automatic outs_t e_exec(input logic [5:0] f);
        outs_t e;
        e = e_base(4'd6);
        e.alu_src_a = 1'b1; e.func_in = f;
        return e;
    endfunction

    function automatic outs_t e_aluwb();
        outs_t e;
        e = e_base(4'd7);
        e.reg_dst = 1'b1; e.reg_write = 1'b1; e.instr_done = 1'b1;
        return e;
    endfunction

    function automatic outs_t e_branch(input logic z);
        outs_t e;
        e = e_base(4'd8);
        e.alu_src_a = 1'b1; e.func_in = 6'b100010; e.branch = 1'b1;
        e.pc_src = 2'b01; e.pc_en = z; e.instr_done = 1'b1;
        return e;
    endfunction

    function automatic outs_t e_addiex();
        outs_t e;
        e = e_base(4'd9);
        e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        return e;
    endfunction

    function automatic outs_t e_addiwb();
        outs_t e;
        e = e_base(4'd10);
        e.reg_write = 1'b1; e.instr_done = 1'b1;
        return e;
    endfunction

`ifdef MC_CTRL_JUMP_EN
    function automatic outs_t e_jump();
        outs_t e;
        e = e_base(4'd11);
        e.pc_src = 2'b10; e.pc_write = 1'b1; e.pc_en = 1'b1; e.instr_done = 1'b1;
        return e;
    endfunction
`endif

    function automatic outs_t e_halt();
        outs_t e;
        e = '0;
        e.st = 4'd12; e.timeout = 1'b1;
        return e;
    endfunction

    // Compare the output vector at the falling edge, then advance one cycle.
    task automatic cyc(input string tag, input outs_t exp_v);
        @(negedge clk);
        total = total + 1;
        assert (act === exp_v) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%h expected=%h", tag, act, exp_v);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; zero = 1'b0; mem_ready = 1'b1;
        opcode = 6'h00; funct = 6'h00;
        @(posedge clk);
        #1;
        cyc("rst_hold", e_zero());
        rst = 1'b0;

        // lw, ready throughout: 5 cycles
        opcode = 6'h23;
        cyc("lw_fetch",  e_fetch(1'b1));
        cyc("lw_decode", e_decode(1'b0));
        cyc("lw_memadr", e_memadr());
        cyc("lw_memrd",  e_memrd());
        cyc("lw_memwb",  e_memwb());

        // R-type add then and: funct passes through in EXEC
        opcode = 6'h00; funct = 6'h20;
        cyc("add_fetch",  e_fetch(1'b1));
        cyc("add_decode", e_decode(1'b0));
        cyc("add_exec",   e_exec(6'h20));
        cyc("add_aluwb",  e_aluwb());
        funct = 6'h24;
        cyc("and_fetch",  e_fetch(1'b1));
        cyc("and_decode", e_decode(1'b0));
        cyc("and_exec",   e_exec(6'h24));
        cyc("and_aluwb",  e_aluwb());

        // beq taken and not taken
        opcode = 6'h04; zero = 1'b1;
        cyc("beq1_fetch",  e_fetch(1'b1));
        cyc("beq1_decode", e_decode(1'b0));
        cyc("beq1_branch", e_branch(1'b1));
        zero = 1'b0;
        cyc("beq0_fetch",  e_fetch(1'b1));
        cyc("beq0_decode", e_decode(1'b0));
        cyc("beq0_branch", e_branch(1'b0));

        // addi
        opcode = 6'h08;
        cyc("addi_fetch",  e_fetch(1'b1));
        cyc("addi_decode", e_decode(1'b0));
        cyc("addi_ex",     e_addiex());
        cyc("addi_wb",     e_addiwb());

        // sw with 3 not-ready cycles in MEMWR
        opcode = 6'h2B;
        cyc("sw_fetch",  e_fetch(1'b1));
        cyc("sw_decode", e_decode(1'b0));
        cyc("sw_memadr", e_memadr());
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("sw_stall", e_memwr(1'b0));
        mem_ready = 1'b1;
        cyc("sw_ready", e_memwr(1'b1));

        // FETCH stalled exactly WAIT_MAX cycles, ready on the limit cycle wins
        opcode = 6'h3F; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) cyc("lim_stall", e_fetch(1'b0));
        mem_ready = 1'b1;
        cyc("lim_ready", e_fetch(1'b1));
        cyc("ill_decode", e_decode(1'b1));

        // opcode 02
        opcode = 6'h02;
        cyc("j_fetch", e_fetch(1'b1));
`ifdef MC_CTRL_JUMP_EN
        cyc("j_decode", e_decode(1'b0));
        cyc("j_jump",   e_jump());
`else
        cyc("j_decode_ill", e_decode(1'b1));
`endif

        // rst during a stalled MEMRD
        opcode = 6'h23;
        cyc("rlw_fetch",  e_fetch(1'b1));
        cyc("rlw_decode", e_decode(1'b0));
        cyc("rlw_memadr", e_memadr());
        mem_ready = 1'b0;
        cyc("rlw_memrd", e_memrd());
        rst = 1'b1;
        cyc("rlw_rst", e_zero());
        rst = 1'b0; mem_ready = 1'b1; opcode = 6'h3F;
        cyc("rlw_after", e_fetch(1'b1));
        cyc("rlw_decode2", e_decode(1'b1));

        // FETCH stuck not-ready: HALT after WAIT_MAX wait cycles
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) cyc("to_stall", e_fetch(1'b0));
        cyc("to_halt0", e_halt());
        cyc("to_halt1", e_halt());
        mem_ready = 1'b1;
        cyc("to_halt_rdy0", e_halt());
        cyc("to_halt_rdy1", e_halt());
        rst = 1'b1;
        cyc("to_rst", e_zero());
        rst = 1'b0;
        cyc("to_recover", e_fetch(1'b1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
